npu_sequencer: RTL and testbench

Autonomous load/run/drain controller for the `npu` core. After `start`, it reads CFG_WORDS configuration words, then IN_WORDS input words, from an external synchronous block ROM. It pushes these words into the NPU config and input FIFOs, respecting their full flags. It then pops OUT_WORDS results from the NPU output FIFO and presents them with a running checksum and a done/error status for board-level self-test.

---
 rtl/npu_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_npu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sequencer.sv
// npu_sequencer: loads config and input words from a block ROM into the NPU
// FIFOs, then drains the result FIFO while keeping a running checksum.
// Every FIFO wait is bounded by TIMEOUT. A timeout sets the sticky error flag
// and still finishes through FIN, so done always pulses.
module npu_sequencer #(
    parameter int ADDR_W    = 11,
    parameter int CFG_WORDS = 312,
    parameter int IN_WORDS  = 4,
    parameter int OUT_WORDS = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [25:0]       cfg_data,
    output logic              cfg_wr_en,
    input  logic              cfg_full,
    output logic [31:0]       in_data,
    output logic              in_wr_en,
    input  logic              in_full,
    output logic              out_rd_en,
    input  logic [31:0]       out_data,
    input  logic              out_empty,
    output logic [31:0]       result_data,
    output logic              result_valid,
    output logic [31:0]       checksum,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int MAXW   = (CFG_WORDS > IN_WORDS)
                          ? ((CFG_WORDS > OUT_WORDS) ? CFG_WORDS : OUT_WORDS)
                          : ((IN_WORDS  > OUT_WORDS) ? IN_WORDS  : OUT_WORDS);
    localparam int CNT_W  = $clog2(MAXW + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CFG_LAST  = CNT_W'(CFG_WORDS - 1);
    localparam logic [CNT_W-1:0]  IN_LAST   = CNT_W'(IN_WORDS - 1);
    localparam logic [CNT_W-1:0]  OUT_LAST  = CNT_W'(OUT_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_FETCH, S_CFG_WRITE, S_IN_FETCH, S_IN_WRITE,
        S_DRAIN, S_RD, S_CAP, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [25:0]         cfg_data_q, cfg_data_d;
    logic                cfg_wr_en_q, cfg_wr_en_d;
    logic [31:0]         in_data_q, in_data_d;
    logic                in_wr_en_q, in_wr_en_d;
    logic                out_rd_en_q, out_rd_en_d;
    logic [31:0]         result_data_q, result_data_d;
    logic                result_valid_q, result_valid_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                timed_out;

    // The current wait cycle is the last one allowed before giving up.
    assign timed_out = (wait_q == WAIT_LAST);

    // Next-state and registered-output logic. Pulses default low, and the wait
    // counter restarts from zero unless the FSM stays in a stalled state.
    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        cnt_d          = cnt_q;
        wait_d         = '0;
        cfg_data_d     = cfg_data_q;
        cfg_wr_en_d    = 1'b0;
        in_data_d      = in_data_q;
        in_wr_en_d     = 1'b0;
        result_data_d  = result_data_q;
        result_valid_d = 1'b0;
        checksum_d     = checksum_q;
        done_d         = 1'b0;
        error_d        = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CFG_FETCH;
                    rom_addr_d = '0;
                    cnt_d      = '0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                end
            end
            S_CFG_FETCH: state_d = S_CFG_WRITE;
            S_CFG_WRITE: begin
                if (!cfg_full) begin
                    cfg_data_d  = rom_data[25:0];
                    cfg_wr_en_d = 1'b1;
                    rom_addr_d  = rom_addr_q + ADDR_W'(1);
                    if (cnt_q == CFG_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IN_FETCH;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_CFG_FETCH;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_IN_FETCH: state_d = S_IN_WRITE;
            S_IN_WRITE: begin
                if (!in_full) begin
                    in_data_d  = rom_data;
                    in_wr_en_d = 1'b1;
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    if (cnt_q == IN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_IN_FETCH;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!out_empty) begin
                    state_d = S_RD;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                result_data_d  = out_data;
                result_valid_d = 1'b1;
                checksum_d     = checksum_q + out_data;
                if (cnt_q == OUT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DRAIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // These flags are registered copies of the next state, so they line up with
    // the state they describe.
    always_comb begin
        out_rd_en_d = (state_d == S_RD);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers. Reset is synchronous and drops any pulse
    // that is in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            rom_addr_q     <= '0;
            cnt_q          <= '0;
            wait_q         <= '0;
            cfg_data_q     <= '0;
            cfg_wr_en_q    <= 1'b0;
            in_data_q      <= '0;
            in_wr_en_q     <= 1'b0;
            out_rd_en_q    <= 1'b0;
            result_data_q  <= '0;
            result_valid_q <= 1'b0;
            checksum_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            cfg_data_q     <= cfg_data_d;
            cfg_wr_en_q    <= cfg_wr_en_d;
            in_data_q      <= in_data_d;
            in_wr_en_q     <= in_wr_en_d;
            out_rd_en_q    <= out_rd_en_d;
            result_data_q  <= result_data_d;
            result_valid_q <= result_valid_d;
            checksum_q     <= checksum_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign cfg_data     = cfg_data_q;
    assign cfg_wr_en    = cfg_wr_en_q;
    assign in_data      = in_data_q;
    assign in_wr_en     = in_wr_en_q;
    assign out_rd_en    = out_rd_en_q;
    assign result_data  = result_data_q;
    assign result_valid = result_valid_q;
    assign checksum     = checksum_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule

// File: tb/tb_npu_sequencer.sv
// Scoreboard bench for npu_sequencer. The stimulus pushes the expected FIFO
// writes, results and done status. Monitors pop and compare them on every
// output pulse. A second instance with TIMEOUT=16 exercises the timeout path.
module tb_npu_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        start, cfg_full, in_full, out_empty;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data, in_data, out_data, result_data, checksum;
    logic [25:0] cfg_data;
    logic        cfg_wr_en, in_wr_en, out_rd_en, result_valid, busy, done, error;

    logic        to_start, to_cfg_wr_en, to_in_wr_en, to_out_rd_en, to_result_valid;
    logic        to_busy, to_done, to_error;
    logic [3:0]  to_rom_addr;
    logic [31:0] to_rom_data, to_in_data, to_result_data, to_checksum;
    logic [25:0] to_cfg_data;

    npu_sequencer #(.ADDR_W(4), .CFG_WORDS(3), .IN_WORDS(2), .OUT_WORDS(2), .TIMEOUT(64)) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .cfg_data(cfg_data), .cfg_wr_en(cfg_wr_en), .cfg_full(cfg_full),
        .in_data(in_data), .in_wr_en(in_wr_en), .in_full(in_full),
        .out_rd_en(out_rd_en), .out_data(out_data), .out_empty(out_empty),
        .result_data(result_data), .result_valid(result_valid), .checksum(checksum),
        .busy(busy), .done(done), .error(error));

    npu_sequencer #(.ADDR_W(4), .CFG_WORDS(3), .IN_WORDS(2), .OUT_WORDS(2), .TIMEOUT(16)) u_to (
        .CLK(CLK), .RST(RST), .start(to_start), .rom_addr(to_rom_addr), .rom_data(to_rom_data),
        .cfg_data(to_cfg_data), .cfg_wr_en(to_cfg_wr_en), .cfg_full(1'b0),
        .in_data(to_in_data), .in_wr_en(to_in_wr_en), .in_full(1'b0),
        .out_rd_en(to_out_rd_en), .out_data(32'h0), .out_empty(1'b1),
        .result_data(to_result_data), .result_valid(to_result_valid), .checksum(to_checksum),
        .busy(to_busy), .done(to_done), .error(to_error));

    // ROM and output-FIFO models
    logic [31:0] rom [16];
    logic [31:0] out_mem [32];
    int          out_avail = 0;
    int          rd_ptr = 0;
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) rom_data <= rom[rom_addr];
    always @(posedge CLK) to_rom_data <= rom[to_rom_addr];
    always @(posedge CLK) if (out_rd_en) begin
        out_data <= out_mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
    end
    assign out_empty = (rd_ptr >= out_avail);

    // scoreboard state
    logic [31:0] exp_cfg[$], exp_in[$], exp_rd[$], exp_rc[$];
    logic        exp_done[$];
    int          exp_to[$];
    int n_cmp = 0, n_bad = 0;
    int n_cfg = 0, n_in = 0, n_res = 0, n_done = 0, to_n_done = 0;
    int first_cfg = -1, done_cyc = 0, c0 = 0;
    int to_last_in = 0, to_err_cyc = 0;
    logic to_err_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: pulse with nothing expected", nm);
    endtask

    // main-instance monitor
    always @(negedge CLK) begin
        if (!RST) begin
            if (cfg_wr_en) begin
                n_cfg++;
                if (first_cfg < 0) first_cfg = cyc;
                if (exp_cfg.size() == 0) unexp("cfg_wr_en");
                else check("cfg_data", 32'(cfg_data), exp_cfg.pop_front());
            end
            if (in_wr_en) begin
                n_in++;
                if (exp_in.size() == 0) unexp("in_wr_en");
                else check("in_data", in_data, exp_in.pop_front());
            end
            if (out_rd_en) check("rd_while_empty", 32'(rd_ptr < out_avail), 32'd1);
            if (result_valid) begin
                n_res++;
                if (exp_rd.size() == 0) unexp("result_valid");
                else begin
                    check("result_data", result_data, exp_rd.pop_front());
                    check("checksum", checksum, exp_rc.pop_front());
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (exp_done.size() == 0) unexp("done");
                else check("done_error", 32'(error), 32'(exp_done.pop_front()));
            end
        end
    end

    // timeout-instance monitor
    always @(negedge CLK) begin
        if (!RST) begin
            if (to_in_wr_en) to_last_in = cyc;
            if (to_error && !to_err_prev) to_err_cyc = cyc;
            if (to_result_valid) unexp("to_result_valid");
            if (to_done) begin
                to_n_done++;
                if (exp_to.size() == 0) unexp("to_done");
                else begin
                    check("to_done_offset", 32'(cyc - to_last_in), 32'(exp_to.pop_front()));
                    check("to_done_error", 32'(to_error), 32'd1);
                end
            end
        end
        to_err_prev = to_error;
    end

    function automatic int get_cnt(input int sel);
        case (sel)
            0: return n_cfg;
            1: return n_in;
            2: return n_res;
            3: return n_done;
            default: return to_n_done;
        endcase
    endfunction

    task automatic wait_cnt(input int sel, input int target, input int budget, input string nm);
        int i = 0;
        while (get_cnt(sel) < target && i < budget) begin
            @(negedge CLK); #1;
            i++;
        end
        if (get_cnt(sel) < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event within %0d cycles", nm, budget);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic pulse(input bit to);
        if (to) to_start = 1'b1; else start = 1'b1;
        c0 = cyc;
        cycles(1);
        to_start = 1'b0;
        start    = 1'b0;
    endtask

    task automatic add_out(input logic [31:0] v);
        out_mem[out_avail] = v;
        out_avail++;
    endtask

    // one full run: cfg 0x100..0x102, in 0x103..0x104, two results, no error
    task automatic expect_run(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] c1);
        exp_cfg.push_back(32'h100); exp_cfg.push_back(32'h101); exp_cfg.push_back(32'h102);
        exp_in.push_back(32'h103);  exp_in.push_back(32'h104);
        exp_rd.push_back(r0); exp_rc.push_back(r0);
        exp_rd.push_back(r1); exp_rc.push_back(c1);
        exp_done.push_back(1'b0);
    endtask

    task automatic check_idle(input string t);
        check({t, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({t, "_cfg_data"}, 32'(cfg_data), 32'd0);
        check({t, "_in_data"}, in_data, 32'd0);
        check({t, "_result_data"}, result_data, 32'd0);
        check({t, "_checksum"}, checksum, 32'd0);
        check({t, "_pulses"}, 32'({cfg_wr_en, in_wr_en, out_rd_en, result_valid}), 32'd0);
        check({t, "_busy"}, 32'(busy), 32'd0);
        check({t, "_done"}, 32'(done), 32'd0);
        check({t, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, i0, r0, k0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
        start = 1'b0; to_start = 1'b0; cfg_full = 1'b0; in_full = 1'b0;
        RST = 1'b1;
        cycles(3);
        check_idle("reset");
        check("reset_to_busy", 32'({to_busy, to_error}), 32'd0);
        RST = 1'b0;
        cycles(1);

        // basic run with timing of first write and done
        expect_run(32'h11, 32'h22, 32'h33);
        add_out(32'h11); add_out(32'h22);
        d0 = n_done; first_cfg = -1;
        pulse(0);
        wait_cnt(3, d0 + 1, 100, "basic_done");
        check("basic_first_cfg_cycle", 32'(first_cfg - c0), 32'd3);
        check("basic_done_cycle", 32'(done_cyc - c0), 32'd18);
        cycles(3);

        // config FIFO full for 5 cycles during the second word
        expect_run(32'h5, 32'h7, 32'hC);
        add_out(32'h5); add_out(32'h7);
        d0 = n_done; k0 = n_cfg;
        pulse(0);
        wait_cnt(0, k0 + 1, 20, "full_first_cfg");
        cfg_full = 1'b1;
        cycles(5);
        cfg_full = 1'b0;
        wait_cnt(3, d0 + 1, 100, "full_done");
        check("full_cfg_count", 32'(n_cfg - k0), 32'd3);
        cycles(3);

        // output FIFO empty for 50 cycles before each result
        expect_run(32'h33, 32'h44, 32'h77);
        d0 = n_done; i0 = n_in; r0 = n_res;
        pulse(0);
        wait_cnt(1, i0 + 2, 40, "empty_in");
        cycles(50);
        add_out(32'h33);
        wait_cnt(2, r0 + 1, 20, "empty_res1");
        cycles(50);
        add_out(32'h44);
        wait_cnt(3, d0 + 1, 100, "empty_done");
        cycles(3);

        // checksum wrap-around
        expect_run(32'hFFFF_FFFF, 32'h2, 32'h1);
        add_out(32'hFFFF_FFFF); add_out(32'h2);
        d0 = n_done;
        pulse(0);
        wait_cnt(3, d0 + 1, 100, "wrap_done");
        cycles(3);

        // timeout with output FIFO stuck empty
        exp_to.push_back(17);
        d0 = to_n_done;
        pulse(1);
        wait_cnt(4, d0 + 1, 100, "to_done");
        check("to_error_rise_offset", 32'(to_err_cyc - to_last_in), 32'd16);
        cycles(2);
        exp_to.push_back(17);
        pulse(1);
        check("to_error_cleared", 32'(to_error), 32'd0);
        check("to_busy_after_start", 32'(to_busy), 32'd1);
        wait_cnt(4, d0 + 2, 100, "to_done2");
        cycles(2);

        // reset during the input phase, then a fresh run with a start while busy
        expect_run(32'h55, 32'h66, 32'hBB);
        add_out(32'h55); add_out(32'h66);
        i0 = n_in;
        pulse(0);
        wait_cnt(1, i0 + 1, 40, "rst_in");
        RST = 1'b1;
        cycles(1);
        check_idle("midrst");
        RST = 1'b0;
        check("midrst_cfg_left", 32'(exp_cfg.size()), 32'd0);
        exp_in.delete(); exp_rd.delete(); exp_rc.delete(); exp_done.delete();
        cycles(1);
        expect_run(32'h55, 32'h66, 32'hBB);
        d0 = n_done;
        pulse(0);
        cycles(3);
        pulse(0);
        wait_cnt(3, d0 + 1, 100, "replay_done");
        cycles(5);
        check("replay_single_done", 32'(n_done - d0), 32'd1);
        check("replay_idle", 32'(busy), 32'd0);

        check("left_cfg", 32'(exp_cfg.size()), 32'd0);
        check("left_in", 32'(exp_in.size()), 32'd0);
        check("left_res", 32'(exp_rd.size()), 32'd0);
        check("left_done", 32'(exp_done.size() + exp_to.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
